// File: rtl/rsa256_exp_ctrl.sv
// rsa256_exp_ctrl: right-to-left square-and-multiply sequencer driving one ModuloProduct and one shared Montgomery unit
module rsa256_exp_ctrl #(
  parameter int WIDTH = 256,
  parameter int CNT_W = 9
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_y,
  input  logic [WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH-1:0] o_result,
  output logic             o_finished,
  output logic             o_busy,
  output logic             o_mp_valid,
  output logic [WIDTH-1:0] o_mp_N,
  output logic [WIDTH-1:0] o_mp_a,
  output logic [WIDTH-1:0] o_mp_b,
  output logic [8:0]       o_mp_k,
  input  logic [WIDTH-1:0] i_mp_result,
  input  logic             i_mp_ready,
  output logic             o_mt_valid,
  output logic [WIDTH-1:0] o_mt_N,
  output logic [WIDTH-1:0] o_mt_a,
  output logic [WIDTH-1:0] o_mt_b,
  input  logic [WIDTH-1:0] i_mt_result,
  input  logic             i_mt_ready
);
  typedef enum logic [3:0] {
    IDLE, PREP_REQ, PREP_WAIT, BIT, MUL_REQ, MUL_WAIT, SQR_REQ, SQR_WAIT, DONE
  } state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] y_q, d_q, n_q, m, t, mt_a, mt_b;
  logic [CNT_W-1:0] cnt;
  logic last;
  assign last = cnt == CNT_W'(WIDTH - 1);
  always_ff @(posedge i_clk) state <= i_rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = i_start ? PREP_REQ : IDLE;
      PREP_REQ:  state_n = PREP_WAIT;
      PREP_WAIT: state_n = i_mp_ready ? BIT : PREP_WAIT;
      BIT:       state_n = d_q[0] ? MUL_REQ : SQR_REQ;
      MUL_REQ:   state_n = MUL_WAIT;
      MUL_WAIT:  state_n = i_mt_ready ? SQR_REQ : MUL_WAIT;
      SQR_REQ:   state_n = SQR_WAIT;
      SQR_WAIT:  state_n = i_mt_ready ? (last ? DONE : BIT) : SQR_WAIT;
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end
  // d_q shifts right once per exponent bit so the current bit is always d_q[0]
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      y_q <= '0;
      d_q <= '0;
      n_q <= '0;
      m <= '0;
      t <= '0;
      mt_a <= '0;
      mt_b <= '0;
      cnt <= '0;
      o_result <= '0;
    end else begin
      if (state == IDLE && i_start) begin
        y_q <= i_y;
        d_q <= i_d;
        n_q <= i_n;
        m <= WIDTH'(1);
        cnt <= '0;
      end
      if (state == PREP_WAIT && i_mp_ready) t <= i_mp_result;
      if (state == BIT) begin
        mt_a <= d_q[0] ? m : t;
        mt_b <= t;
      end
      if (state == MUL_WAIT && i_mt_ready) begin
        m <= i_mt_result;
        mt_a <= t;
      end
      if (state == SQR_WAIT && i_mt_ready) begin
        t <= i_mt_result;
        d_q <= d_q >> 1;
        cnt <= cnt + CNT_W'(!last);
        if (last) o_result <= m;
      end
    end
  end
  assign o_busy = state != IDLE;
  assign o_finished = state == DONE;
  assign o_mp_valid = state == PREP_REQ;
  assign o_mt_valid = state == MUL_REQ || state == SQR_REQ;
  assign o_mp_N = n_q;
  assign o_mp_a = '0;
  assign o_mp_b = y_q;
  assign o_mp_k = 9'(WIDTH);
  assign o_mt_N = n_q;
  assign o_mt_a = mt_a;
  assign o_mt_b = mt_b;
endmodule
